// File: rtl/wb_pkg.sv
// Shared constants for the writeback port arbiter: default geometry,
// the hard-wired zero register and the fixed requester slots.
package wb_pkg;

  localparam int DEF_NREQ = 3;
  localparam int DEF_AW   = 5;
  localparam int DEF_DW   = 32;

  // r0 reads as zero; writes aimed at it are accepted but never committed.
  localparam int REG_ZERO = 0;

  // Requester slot assignment on the writeback port.
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_MUL = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority arbiter: the search starts one slot past ptr and wraps,
// so the most recently served requester has the lowest priority.
// Purely combinational.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  int            sum;
  logic [IW-1:0] idx;

  // Walk slots ptr+1 .. ptr+N (mod N) and grant the first one requesting.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      sum = int'(ptr) + k;
      if (sum >= N) sum = sum - N;
      idx = IW'(sum);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the register file's single write port
// between NREQ requesters (ALU, load unit, multiplier) with round-robin
// priority, one grant per cycle, and a registered write stage.
// Optional macro WB_SCOREBOARD_EN adds an issue-side pending-write
// scoreboard (issue_valid/issue_rd in, pending out).
//
// Handshake: a requester raises req_valid with req_rd/req_data and holds all
// three stable until it sees req_ready; the transfer happens on the rising
// edge where req_valid && req_ready. req_ready is a function of req_valid and
// the round-robin pointer only, never of the payload.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*AW-1:0]       req_rd,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [AW-1:0]            rf_rd,
  output logic [DW-1:0]            rf_write_data,
  output logic                     rf_reg_write,
`ifdef WB_SCOREBOARD_EN
  input  logic                     issue_valid,
  input  logic [AW-1:0]            issue_rd,
  output logic [31:0]              pending,
`endif
  output logic [$clog2(NREQ)-1:0]  grant_idx
);

  localparam int IW = $clog2(NREQ);

  // Pointer rests on the slot just before the ALU so the ALU wins first.
  localparam logic [IW-1:0] PTR_RST = IW'((REQ_ALU + NREQ - 1) % NREQ);

  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_idx;
  logic [NREQ-1:0] gnt;
  logic          acc;
  logic [AW-1:0] acc_rd;
  logic [DW-1:0] acc_data;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign acc       = |gnt;

  // Select the granted requester's payload (gnt is one-hot or zero).
  always_comb begin
    acc_rd   = '0;
    acc_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        acc_rd   = req_rd[i*AW +: AW];
        acc_data = req_data[i*DW +: DW];
      end
    end
  end

  // Pointer and write stage; rf_rd/rf_write_data hold when idle, and a
  // transfer to r0 is consumed without raising the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= PTR_RST;
      grant_idx     <= '0;
      rf_rd         <= '0;
      rf_write_data <= '0;
      rf_reg_write  <= 1'b0;
    end else begin
      rf_reg_write <= 1'b0;
      if (acc) begin
        ptr           <= gnt_idx;
        grant_idx     <= gnt_idx;
        rf_rd         <= acc_rd;
        rf_write_data <= acc_data;
        rf_reg_write  <= (acc_rd != AW'(REG_ZERO));
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] pending_q;
  logic [31:0] pending_nxt;

  // Clear on writeback first, then set on issue: a same-edge issue marks a
  // newer producer, so its set must survive the older write's clear.
  always_comb begin
    pending_nxt = pending_q;
    if (acc) pending_nxt[acc_rd] = 1'b0;
    if (issue_valid) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[REG_ZERO] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_nxt;
  end

  assign pending = pending_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vectors, a round-robin reference model
// with an expected-write queue checked every falling edge, and an assertion
// on the requester hold rule. WB_SCOREBOARD_EN adds the pending-bit test.
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int NREQ = DEF_NREQ;
  localparam int AW   = DEF_AW;
  localparam int DW   = DEF_DW;
  localparam int IW   = $clog2(NREQ);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      rf_rd;
  logic [DW-1:0]      rf_write_data;
  logic               rf_reg_write;
  logic [IW-1:0]      grant_idx;
`ifdef WB_SCOREBOARD_EN
  logic               issue_valid;
  logic [AW-1:0]      issue_rd;
  logic [31:0]        pending;
`endif

  wb_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_rd        (req_rd),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rf_rd         (rf_rd),
    .rf_write_data (rf_write_data),
    .rf_reg_write  (rf_reg_write),
`ifdef WB_SCOREBOARD_EN
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .pending       (pending),
`endif
    .grant_idx     (grant_idx)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  logic [NREQ-1:0] dv;
  logic [AW-1:0]   drd   [NREQ];
  logic [DW-1:0]   ddata [NREQ];
  logic [NREQ-1:0] acc_neg;

  task automatic apply();
    req_valid = dv;
    for (int i = 0; i < NREQ; i++) begin
      req_rd[i*AW +: AW]   = drd[i];
      req_data[i*DW +: DW] = ddata[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    step();
    rst_n = 1'b0;
    dv = '0;
    apply();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Retire accepted requests one edge at a time until nothing is valid.
  task automatic drain();
    for (int n = 0; n < 4*NREQ && dv != '0; n++) begin
      step();
      dv = dv & ~acc_neg;
      apply();
    end
    chk("drain_done", dv, '0);
  endtask

  // Which requests will transfer at the next rising edge.
  always @(negedge clk) acc_neg = req_valid & req_ready;

  // ---------------- requester hold rule ----------------
  for (genvar g = 0; g < NREQ; g++) begin : g_rule
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[g] && !req_ready[g]) |=>
        (req_valid[g] && $stable(req_rd[g*AW +: AW]) && $stable(req_data[g*DW +: DW])))
      else begin
        fails++;
        $display("FAIL hold_rule req%0d: got dropped/changed payload, expected stable until ready", g);
      end
  end

  // ---------------- reference model ----------------
  // Last served slot; the next grant is the first valid slot after it.
  int            m_last = NREQ - 1;
  int            m_gidx = 0;
  int            m_g;
  logic          m_we   = 1'b0;
  logic [AW-1:0] m_rd   = '0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] exp_q[$];

  function automatic int exp_grant();
    int i;
    for (int k = 1; k <= NREQ; k++) begin
      i = (m_last + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = NREQ - 1;
      m_gidx = 0;
      m_we   = 1'b0;
      m_rd   = '0;
      m_data = '0;
      exp_q.delete();
    end else begin
      m_g  = exp_grant();
      m_we = 1'b0;
      if (m_g >= 0) begin
        m_last = m_g;
        m_gidx = m_g;
        m_rd   = req_rd[m_g*AW +: AW];
        m_data = req_data[m_g*DW +: DW];
        m_we   = (m_rd != '0);
        if (m_we) exp_q.push_back(m_data);
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [NREQ-1:0] exp_rdy;
  int              cmp_g;
  logic [DW-1:0]   exp_w;

  always @(negedge clk) begin
    exp_rdy = '0;
    cmp_g   = exp_grant();
    if (cmp_g >= 0) exp_rdy[cmp_g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("rf_reg_write", rf_reg_write, m_we);
    chk("grant_idx", grant_idx, m_gidx);
    chk("rf_rd", rf_rd, m_rd);
    chk("rf_write_data", rf_write_data, m_data);
    if (rf_reg_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL write_order: got write 0x%0h, expected no write", rf_write_data);
      end else begin
        exp_w = exp_q.pop_front();
        chk("write_order", rf_write_data, exp_w);
      end
    end
  end

  // ---------------- directed tests ----------------
  int order [6] = '{0, 1, 2, 0, 1, 2};
  int wait2;
  int nrun;

  initial begin
    dv = '0;
    for (int i = 0; i < NREQ; i++) begin
      drd[i]   = '0;
      ddata[i] = '0;
    end
    apply();
`ifdef WB_SCOREBOARD_EN
    issue_valid = 1'b0;
    issue_rd    = '0;
`endif

    // Reset values
    @(posedge clk);
    @(negedge clk);
    chk("rst_reg_write", rf_reg_write, 1'b0);
    chk("rst_rd", rf_rd, '0);
    chk("rst_data", rf_write_data, '0);
    chk("rst_grant_idx", grant_idx, '0);
    rst_n = 1'b1;

    // Single requester
    step();
    dv = 3'b010; drd[REQ_MEM] = 5'd7; ddata[REQ_MEM] = 32'hDEADBEEF;
    apply();
    @(negedge clk);
    chk("single_ready", req_ready, 3'b010);
    step();
    dv = '0;
    apply();
    @(negedge clk);
    chk("single_we", rf_reg_write, 1'b1);
    chk("single_rd", rf_rd, 5'd7);
    chk("single_data", rf_write_data, 32'hDEADBEEF);
    chk("single_gidx", grant_idx, 1);

    // All three valid: grant order 0,1,2,0,1,2
    reset_dut();
    step();
    dv = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      drd[i]   = AW'(10 + i);
      ddata[i] = 32'hA000 + i;
    end
    apply();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rr_order", req_ready, 3'b001 << order[c]);
      if (c > 0) chk("rr_write_each_cycle", rf_reg_write, 1'b1);
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (acc_neg[i]) begin
          drd[i]   = AW'(16 + c + i);
          ddata[i] = $urandom;
        end
      end
      apply();
    end
    drain();

    // Write to r0: accepted, not committed, pointer still advances
    reset_dut();
    step();
    dv = 3'b001; drd[REQ_ALU] = '0; ddata[REQ_ALU] = 32'd5;
    apply();
    @(negedge clk);
    chk("r0_ready", req_ready, 3'b001);
    step();
    dv = 3'b011;
    drd[REQ_ALU] = 5'd4; ddata[REQ_ALU] = 32'd6;
    drd[REQ_MEM] = 5'd3; ddata[REQ_MEM] = 32'd7;
    apply();
    @(negedge clk);
    chk("r0_no_write", rf_reg_write, 1'b0);
    chk("r0_rd_captured", rf_rd, '0);
    chk("r0_next_grant", req_ready, 3'b010);
    drain();

    // Multiplier held valid, others toggling: bounded wait
    reset_dut();
    step();
    dv[REQ_MUL] = 1'b1; drd[REQ_MUL] = 5'd21; ddata[REQ_MUL] = $urandom;
    apply();
    wait2 = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_valid[REQ_MUL] && !req_ready[REQ_MUL]) wait2++;
      else wait2 = 0;
      chk("fair_mul_wait", (wait2 < NREQ), 1'b1);
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!dv[i] || acc_neg[i]) begin
          dv[i]    = (i == REQ_MUL) ? 1'b1 : 1'($urandom_range(0, 1));
          drd[i]   = AW'($urandom_range(0, 31));
          ddata[i] = $urandom;
        end
      end
      apply();
    end
    drain();

    // Reset in the middle of a full stream
    step();
    dv = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      drd[i]   = AW'(i + 1);
      ddata[i] = $urandom;
    end
    apply();
    nrun = $urandom_range(2, 5);
    for (int c = 0; c < nrun; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (acc_neg[i]) ddata[i] = $urandom;
      end
      apply();
    end
    @(posedge clk);
    #($urandom_range(1, 4));
    rst_n = 1'b0;
    #1;
    chk("midrst_we", rf_reg_write, 1'b0);
    chk("midrst_gidx", grant_idx, '0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_first_grant", req_ready, 3'b001);
    drain();

`ifdef WB_SCOREBOARD_EN
    // Pending bits: set, same-edge set wins over clear, later clear
    reset_dut();
    step();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    dv = 3'b001; drd[REQ_ALU] = 5'd9; ddata[REQ_ALU] = 32'h99;
    apply();
    @(negedge clk);
    chk("pend_set", pending[9], 1'b1);
    step();
    issue_valid = 1'b0;
    dv = '0;
    apply();
    @(negedge clk);
    chk("pend_set_wins", pending[9], 1'b1);
    step();
    dv = 3'b010; drd[REQ_MEM] = 5'd9; ddata[REQ_MEM] = 32'h77;
    apply();
    step();
    dv = '0;
    apply();
    @(negedge clk);
    chk("pend_clear", pending[9], 1'b0);
    chk("pend_r0", pending[0], 1'b0);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
